// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_ctrl
//  Purpose  : Command-driven SPI master. Turns one parallel command
//             (2-bit op + 8-bit payload) into an 11-bit serial frame
//             (control bit + op + payload, MSB first) on SS_n/MOSI. For
//             read-data commands it waits TURN_CYC turnaround cycles and
//             then collects an 8-bit reply from MISO, MSB first.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             cmd_valid/ready  - command handshake
//             cmd_op, cmd_data - 00 wr-addr, 01 wr-data, 10 rd-addr,
//                                11 rd-data; payload byte
//             SS_n, MOSI, MISO - SPI bus (SS_n active low)
//             rsp_valid/data   - read-data reply (one-cycle pulse)
//             done             - one-cycle pulse at the end of every frame
//             busy             - high from acceptance until back in IDLE
//             err              - sequence-error pulse
//  Options  : SPI_CTRL_SEQ_CHECK_EN - when defined, a read-data without a
//             preceding read-addr, or a write-data before any write-addr
//             since reset, is rejected with an err pulse and no frame.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int TURN_CYC = 2,   // turnaround cycles before first MISO sample
    parameter int IDLE_GAP = 1    // minimum SS_n-high cycles between frames
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CTRL  = 3'd1,
        S_SHIFT = 3'd2,
        S_TURN  = 3'd3,
        S_READ  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam logic [3:0] C_TURN_LAST  = 4'(TURN_CYC - 1);
    localparam logic [3:0] C_GAP_LAST   = 4'(IDLE_GAP - 1);
    localparam logic [3:0] C_SHIFT_LAST = 4'd9;
    localparam logic [3:0] C_READ_LAST  = 4'd7;
    localparam logic [1:0] C_OP_WA      = 2'b00;
    localparam logic [1:0] C_OP_WD      = 2'b01;
    localparam logic [1:0] C_OP_RA      = 2'b10;
    localparam logic [1:0] C_OP_RD      = 2'b11;

    state_t     r_state;
    logic [3:0] r_cnt;        // down-counter shared by SHIFT/TURN/READ/GAP
    logic [1:0] r_op;         // op of the frame in flight
    logic [9:0] r_sh;         // outgoing frame, MSB drives MOSI next
    logic [6:0] r_rx;         // first seven MISO bits of the reply
    logic       r_ss_n;
    logic       r_mosi;
    logic       r_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_done;
    logic       r_busy;

`ifdef SPI_CTRL_SEQ_CHECK_EN
    logic r_err;
    logic r_rd_addr_seen;
    logic r_wr_addr_seen;
    logic w_seq_bad;

    // A command is out of sequence if its addressing frame is missing.
    assign w_seq_bad = ((cmd_op == C_OP_RD) && !r_rd_addr_seen) ||
                       ((cmd_op == C_OP_WD) && !r_wr_addr_seen);
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 2'b00;
            r_sh        <= 10'd0;
            r_rx        <= 7'd0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SPI_CTRL_SEQ_CHECK_EN
            r_err          <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_wr_addr_seen <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef SPI_CTRL_SEQ_CHECK_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (cmd_valid && r_ready) begin
`ifdef SPI_CTRL_SEQ_CHECK_EN
                        // Rejected command: stay in IDLE, bus untouched.
                        if (w_seq_bad) begin
                            r_err <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= S_CTRL;
                            r_op    <= cmd_op;
                            r_sh    <= {cmd_op, cmd_data};
                            r_ss_n  <= 1'b0;
                            r_mosi  <= cmd_op[1];
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_CTRL: begin
                    r_state <= S_SHIFT;
                    r_cnt   <= C_SHIFT_LAST;
                    r_mosi  <= r_sh[9];
                    r_sh    <= {r_sh[8:0], 1'b0};
                end

                S_SHIFT: begin
                    if (r_cnt == 4'd0) begin
                        r_mosi <= 1'b0;
                        if (r_op == C_OP_RD) begin
                            r_state <= S_TURN;
                            r_cnt   <= C_TURN_LAST;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= C_GAP_LAST;
                            r_ss_n  <= 1'b1;
                            r_done  <= 1'b1;
`ifdef SPI_CTRL_SEQ_CHECK_EN
                            if (r_op == C_OP_RA) r_rd_addr_seen <= 1'b1;
                            if (r_op == C_OP_WA) r_wr_addr_seen <= 1'b1;
`endif
                        end
                    end else begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_mosi <= r_sh[9];
                        r_sh   <= {r_sh[8:0], 1'b0};
                    end
                end

                S_TURN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_READ;
                        r_cnt   <= C_READ_LAST;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_READ: begin
                    r_rx <= {r_rx[5:0], MISO};
                    if (r_cnt == 4'd0) begin
                        // The eighth bit is taken straight from MISO.
                        r_state     <= S_GAP;
                        r_cnt       <= C_GAP_LAST;
                        r_ss_n      <= 1'b1;
                        r_done      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {r_rx, MISO};
`ifdef SPI_CTRL_SEQ_CHECK_EN
                        r_rd_addr_seen <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_GAP: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_ctrl
//  Purpose  : Self-checking bench for spi_master_ctrl. A frame-level model
//             derives the expected SS_n/MOSI waveform, done/rsp timing and
//             handshake timing of each command from its op and payload,
//             and a slave model drives the reply byte onto MISO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int TURN_CYC = 2;
    localparam int IDLE_GAP = 1;
`ifdef SPI_CTRL_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       MISO = 1'b0;
    wire        cmd_ready, SS_n, MOSI, rsp_valid, done, busy, err;
    wire  [7:0] rsp_data;

    spi_master_ctrl #(.TURN_CYC(TURN_CYC), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: last reply byte and the sequence-tracking flags.
    logic [7:0] m_rsp = 8'h00;
    bit         m_rd_seen = 1'b0;
    bit         m_wr_seen = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic [7:0]  miso;
        logic [10:0] exp_mosi;
        int          exp_len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int frame_len(input logic [1:0] op);
        return (op == 2'b11) ? (11 + TURN_CYC + 8) : 11;
    endfunction

    // Issue one command and check every cycle of its frame. Called and
    // returning at a negedge; on return the DUT is ready for the next one.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           input logic [7:0] miso_byte, input logic [10:0] exp_mosi,
                           input int exp_len);
        int  wait_n;
        int  first_read;
        int  idx;
        logic bad;
        logic exp_m;
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready !== 1'b1) return;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        MISO      = 1'($urandom);
        bad = SEQ_EN && (((op == 2'b11) && !m_rd_seen) || ((op == 2'b01) && !m_wr_seen));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);

        if (bad) begin
            chk("seq_err_pulse", {31'd0, err}, 32'd1);
            chk("seq_ss_n", {31'd0, SS_n}, 32'd1);
            chk("seq_busy", {31'd0, busy}, 32'd0);
            chk("seq_done", {31'd0, done}, 32'd0);
            chk("seq_ready", {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
            chk("seq_err_end", {31'd0, err}, 32'd0);
            chk("seq_ss_n2", {31'd0, SS_n}, 32'd1);
            chk("seq_done2", {31'd0, done}, 32'd0);
            chk("seq_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("seq_rsp_data", {24'd0, rsp_data}, {24'd0, m_rsp});
            return;
        end

        first_read = 12 + TURN_CYC;
        for (int k = 1; k <= exp_len + IDLE_GAP + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (op == 2'b11 && k == exp_len + 1) m_rsp = miso_byte;
            idx   = 11 - k;
            exp_m = (k <= 11) ? exp_mosi[idx] : 1'b0;
            chk($sformatf("ss_n op=%0d k=%0d", op, k), {31'd0, SS_n}, {31'd0, (k > exp_len)});
            chk($sformatf("mosi op=%0d k=%0d", op, k), {31'd0, MOSI}, {31'd0, exp_m});
            chk($sformatf("done op=%0d k=%0d", op, k), {31'd0, done}, {31'd0, (k == exp_len + 1)});
            chk($sformatf("rsp_valid op=%0d k=%0d", op, k), {31'd0, rsp_valid},
                {31'd0, (op == 2'b11 && k == exp_len + 1)});
            chk($sformatf("rsp_data op=%0d k=%0d", op, k), {24'd0, rsp_data}, {24'd0, m_rsp});
            chk($sformatf("busy op=%0d k=%0d", op, k), {31'd0, busy}, {31'd0, (k <= exp_len + IDLE_GAP)});
            chk($sformatf("ready op=%0d k=%0d", op, k), {31'd0, cmd_ready},
                {31'd0, (k == exp_len + IDLE_GAP + 1)});
            chk($sformatf("err op=%0d k=%0d", op, k), {31'd0, err}, 32'd0);
            // Slave drives the reply during the eight sampling cycles only.
            if (k >= first_read && k < first_read + 8) MISO = miso_byte[7 - (k - first_read)];
            else MISO = 1'($urandom);
        end
        if (op == 2'b10) m_rd_seen = 1'b1;
        if (op == 2'b11) m_rd_seen = 1'b0;
        if (op == 2'b00) m_wr_seen = 1'b1;
    endtask

    initial begin
        logic [1:0] r_op_rand;
        logic [7:0] r_data_rand;
        logic [1:0] b2b_ops[3];
        int  hs, dn, lows, falls, errs, b2b_idx;
        logic prev_ss, hs_now;

        vecs[0] = '{op: 2'b00, data: 8'h3C, miso: 8'h00, exp_mosi: 11'b00000111100, exp_len: 11};
        vecs[1] = '{op: 2'b10, data: 8'h3C, miso: 8'h00, exp_mosi: 11'b11000111100, exp_len: 11};
        vecs[2] = '{op: 2'b11, data: 8'h00, miso: 8'hA5, exp_mosi: 11'b11100000000, exp_len: 21};
        vecs[3] = '{op: 2'b01, data: 8'h5A, miso: 8'h00, exp_mosi: 11'b00101011010, exp_len: 11};
        vecs[4] = '{op: 2'b10, data: 8'hFF, miso: 8'h00, exp_mosi: 11'b11011111111, exp_len: 11};
        vecs[5] = '{op: 2'b11, data: 8'h77, miso: 8'h81, exp_mosi: 11'b11101110111, exp_len: 21};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_ss_n", {31'd0, SS_n}, 32'd1);
        chk("idle_mosi", {31'd0, MOSI}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);

        // Read-data straight after reset (rejected when sequence checking is on)
        run_cmd(2'b11, 8'h00, 8'hC3, 11'b11100000000, frame_len(2'b11));

        // Table-driven frames
        for (int i = 0; i < 6; i++)
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].miso, vecs[i].exp_mosi, vecs[i].exp_len);

        // Reset in the middle of a SHIFT
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_ss_low", {31'd0, SS_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        m_rsp = 8'h00; m_rd_seen = 1'b0; m_wr_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done %0d", i), {31'd0, done}, 32'd0);
            chk($sformatf("post_rst_ss_n %0d", i), {31'd0, SS_n}, 32'd1);
        end
        run_cmd(2'b00, 8'h12, 8'h00, 11'b00000010010, 11);
        run_cmd(2'b01, 8'h9E, 8'h00, 11'b00110011110, 11);

        // cmd_valid held across three back-to-back commands
        b2b_ops[0] = 2'b00; b2b_ops[1] = 2'b01; b2b_ops[2] = 2'b10;
        hs = 0; dn = 0; lows = 0; falls = 0; errs = 0; b2b_idx = 0; prev_ss = SS_n;
        cmd_valid = 1'b1; cmd_op = b2b_ops[0]; cmd_data = 8'($urandom);
        for (int c = 0; c < 60; c++) begin
            hs_now = cmd_valid && (cmd_ready === 1'b1);
            if (hs_now) hs++;
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (err === 1'b1) errs++;
            if (SS_n === 1'b0) lows++;
            if (prev_ss === 1'b1 && SS_n === 1'b0) falls++;
            prev_ss = SS_n;
            if (hs_now) begin
                b2b_idx++;
                if (b2b_idx < 3) begin
                    cmd_op = b2b_ops[b2b_idx]; cmd_data = 8'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        chk("b2b_handshakes", hs, 3);
        chk("b2b_done_pulses", dn, 3);
        chk("b2b_ss_low_cycles", lows, 33);
        chk("b2b_frames", falls, 3);
        chk("b2b_err", errs, 0);
        m_wr_seen = 1'b1; m_rd_seen = 1'b1;

        // Randomised commands against the frame model
        for (int i = 0; i < 20; i++) begin
            r_op_rand   = 2'($urandom_range(0, 3));
            r_data_rand = 8'($urandom);
            run_cmd(r_op_rand, r_data_rand, 8'($urandom),
                    {r_op_rand[1], r_op_rand, r_data_rand}, frame_len(r_op_rand));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Command-driven SPI master that sequences frames into the SPI-slave/RAM subsystem over SS_n/MOSI/MISO.
- Converts one parallel command (op + 8-bit payload) into an 11-bit serial frame.
- For read-data commands, also collects the 8-bit MISO reply and returns it on a response port.
- Sits between a host/test sequencer and the SPI wrapper; shares the same clock as the slave.

Parameters:
- TURN_CYC, 2, idle cycles after the last MOSI bit of a read-data frame before the first MISO sample (1..7).
- IDLE_GAP, 1, minimum cycles SS_n stays high between frames (1..7).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  in  8  address or write payload (don't-care for 11).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- rsp_valid  out  1  one-cycle pulse, rsp_data valid.
- rsp_data  out  8  byte read back on a read-data frame.
- done  out  1  one-cycle pulse at the end of every frame.
- busy  out  1  high from acceptance until return to IDLE.
- err  out  1  sequence-error pulse (see Optional Feature).

Behaviour:
- Reset (clk and rst only): state IDLE, SS_n=1, MOSI=0, cmd_ready=0 during rst then 1, rsp_valid=0, rsp_data=0, done=0, busy=0, err=0, all counters 0.
- Reset asserted mid-frame: SS_n=1 at the next edge, frame abandoned, no done/rsp pulse.
- States: IDLE, CTRL, SHIFT, TURN, READ, GAP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - Handshake is cmd_valid && cmd_ready at edge T; latch frame[9:0]={cmd_op,cmd_data}; go to CTRL.
  - cmd_valid while not ready is ignored; the host must hold it.
- CTRL (cycle T+1):
  - SS_n=0, MOSI=cmd_op[1] (control bit: 0 write, 1 read).
  - busy=1 from T+1.
- SHIFT (T+2..T+11): MOSI=frame[9] down to frame[0], one bit per cycle; 4-bit counter 9→0.
- After SHIFT:
  - op≠11: go to GAP.
  - op=11: go to TURN.
- TURN: SS_n=0, MOSI=0 for TURN_CYC cycles.
- READ:
  - SS_n=0 for 8 cycles.
  - MISO sampled at each posedge and shifted in MSB first.
  - At exit, rsp_data is loaded and rsp_valid pulses in the first GAP cycle.
- GAP:
  - SS_n=1, MOSI=0.
  - done pulses in the first GAP cycle.
  - Stays IDLE_GAP cycles, then IDLE.
- Frame lengths with SS_n low: 11 cycles for op≠11; 11+TURN_CYC+8 cycles for op=11 (21 at default).
- With IDLE_GAP=1, the next command is accepted at the earliest 13 cycles after T for op≠11.
- rsp_data holds its last value until the next read-data frame completes.
- SS_n never glitches: it changes only on state transitions into CTRL and into GAP.

Optional Feature:
- Macro: SPI_CTRL_SEQ_CHECK_EN.
- Defined:
  - Flag rd_addr_seen is set when a read-addr frame completes and cleared when a read-data frame completes; both reset to 0.
  - A read-data command accepted while rd_addr_seen=0 sends no frame: SS_n stays 1, err pulses at T+1, no done, returns to IDLE at T+1.
  - write-data accepted before any write-addr since reset is handled the same way.
- Undefined: no tracking, err tied to 0, every command is framed.

Test Plan:
- Reset then idle → SS_n=1, MOSI=0, cmd_ready=1, busy=0, all pulses 0.
- Write-addr cmd_data=8'h3C accepted at T → SS_n low T+1..T+11; MOSI bits 0,0,0,0,0,1,1,1,1,0,0; done at T+12; cmd_ready back at T+13.
- Read-addr 8'h3C, then read-data with slave model driving 8'hA5 → second frame SS_n low 21 cycles; rsp_valid pulses with rsp_data=8'hA5 alongside done.
- rst asserted at bit 5 of SHIFT → SS_n=1 next edge, no done; the next write-data frame completes normally.
- cmd_valid held during a busy frame → accepted only once cmd_ready=1; exactly one frame per handshake over 3 back-to-back commands.
- With SPI_CTRL_SEQ_CHECK_EN, read-data right after reset → err pulse at T+1, SS_n stays 1, no rsp_valid.
